sum_accumulator_16bit: RTL and testbench

//   Downstream stage of the 16-bit adder. Takes the adder's sum word over a

---
 rtl/sum_accumulator_16bit.sv | 175 +++++++++++++++++
 tb/tb_sum_accumulator_16bit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator_16bit.sv
// sum_accumulator_16bit
//   Block-sum stage placed after the 16-bit adder. Accepts adder sum words over
//   a valid/ready handshake, accumulates COUNT of them (or fewer when flushed)
//   into an ACC_W-bit total, and presents total, beat count and a sticky
//   wrap flag on a registered valid/ready output port.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous active-high reset
//   in_valid   in   1       in_sum holds a valid adder result
//   in_ready   out  1       stage can accept in_sum this cycle (from state)
//   in_sum     in   DATA_W  adder sum word, unsigned
//   flush      in   1       close the current block early
//   out_valid  out  1       block result available
//   out_ready  in   1       consumer takes the result this cycle
//   out_total  out  ACC_W   accumulated total of the block (mod 2^ACC_W)
//   out_count  out  8       number of sums in the block
//   out_ovf    out  1       total wrapped during the block
module sum_accumulator_16bit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COUNT  = 4,
  parameter int unsigned ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_total,
  output logic [7:0]        out_count,
  output logic              out_ovf
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state, state_d;

  logic [ACC_W-1:0] acc, acc_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             ovf, ovf_d;

  logic [ACC_W-1:0] out_total_d;
  logic [CNT_W-1:0] out_count_d;
  logic             out_ovf_d;
  logic             out_valid_d;

  logic             xfer;
  logic             handoff;
  logic [SUM_W-1:0] add_full;
  logic [CNT_W-1:0] cnt_inc;
  logic             close_blk;

  // Ready depends only on state (and out_ready while holding a result)
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    in_ready = 1'b1;
        ACCUM:   in_ready = 1'b1;
        HOLD:    in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign xfer    = in_valid & in_ready;
  assign handoff = out_valid & out_ready;

  // One extra bit catches the carry out of the accumulator width
  assign add_full = SUM_W'(acc) + SUM_W'(in_sum);
  assign cnt_inc  = cnt + CNT_W'(1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, accumulator update and result capture
  always_comb begin
    state_d     = state;
    acc_d       = acc;
    cnt_d       = cnt;
    ovf_d       = ovf;
    out_total_d = out_total;
    out_count_d = out_count;
    out_ovf_d   = out_ovf;
    out_valid_d = out_valid;
    close_blk   = 1'b0;

    case (state)
      IDLE: begin
        if (xfer) begin
          acc_d   = ACC_W'(in_sum);
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end

      ACCUM: begin
        if (xfer) begin
          acc_d = add_full[ACC_W-1:0];
          cnt_d = cnt_inc;
          ovf_d = ovf | add_full[ACC_W];
        end
        // A flush in the same cycle as a beat closes the block with that beat included
        close_blk = (xfer && (cnt_inc == CNT_LAST)) || flush;
        if (close_blk) begin
          out_total_d = acc_d;
          out_count_d = cnt_d;
          out_ovf_d   = ovf_d;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        // in_ready follows out_ready here, so a beat can only arrive with a handoff
        if (handoff) begin
          out_valid_d = 1'b0;
          if (xfer) begin
            acc_d   = ACC_W'(in_sum);
            cnt_d   = CNT_W'(1);
            ovf_d   = 1'b0;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_total <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      acc       <= acc_d;
      cnt       <= cnt_d;
      ovf       <= ovf_d;
      out_total <= out_total_d;
      out_count <= out_count_d;
      out_ovf   <= out_ovf_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_sum_accumulator_16bit.sv
module tb_sum_accumulator_16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_sum;
  logic        flush;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_ovf_a;
  logic [23:0] out_total_a;
  logic [7:0]  out_count_a;

  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [16:0] out_total_b;
  logic [7:0]  out_count_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] total;
    logic [7:0]  count;
    logic        ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  sum_accumulator_16bit #(.DATA_W(16), .COUNT(4), .ACC_W(24)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_sum(in_sum), .flush(flush), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_total(out_total_a), .out_count(out_count_a), .out_ovf(out_ovf_a)
  );

  sum_accumulator_16bit #(.DATA_W(16), .COUNT(4), .ACC_W(17)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_sum(in_sum), .flush(flush), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_total(out_total_b), .out_count(out_count_b), .out_ovf(out_ovf_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] t_a, input logic o_a,
                          input logic [31:0] t_b, input logic o_b, input logic [7:0] c);
    exp_t e;
    e.total = t_a; e.count = c; e.ovf = o_a;
    q_a.push_back(e);
    e.total = t_b; e.ovf = o_b;
    q_b.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [15:0] s, input logic fl);
    logic got;
    got = 1'b0;
    in_valid = 1'b1;
    in_sum   = s;
    flush    = fl;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      got = in_ready_a;
      @(posedge clk);
      #1;
      if (got) break;
    end
    chk("beat_accepted", 32'(got), 32'd1);
    in_valid = 1'b0;
    flush    = 1'b0;
    in_sum   = 16'hDEAD;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitors: one per instance, popping on every output handoff
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid_a && out_ready) begin
        if (q_a.size() == 0) begin
          chk("a_unexpected_output", 32'(out_total_a), 32'hFFFF_FFFF);
        end else begin
          e = q_a.pop_front();
          chk("a_total", 32'(out_total_a), e.total);
          chk("a_count", 32'(out_count_a), 32'(e.count));
          chk("a_ovf",   32'(out_ovf_a),   32'(e.ovf));
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid_b && out_ready) begin
        if (q_b.size() == 0) begin
          chk("b_unexpected_output", 32'(out_total_b), 32'hFFFF_FFFF);
        end else begin
          e = q_b.pop_front();
          chk("b_total", 32'(out_total_b), e.total);
          chk("b_count", 32'(out_count_b), 32'(e.count));
          chk("b_ovf",   32'(out_ovf_b),   32'(e.ovf));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = 16'h0000;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #1;
    chk("rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("rst_in_ready",  32'(in_ready_a),  32'd0);
    chk("rst_out_total", 32'(out_total_a), 32'd0);
    chk("rst_out_count", 32'(out_count_a), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(1);
    chk("idle_in_ready", 32'(in_ready_a), 32'd1);

    // 1: four back-to-back beats, 1-cycle latency
    push_exp(32'h00000A, 1'b0, 32'h00000A, 1'b0, 8'd4);
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b0);
    send(16'h0003, 1'b0);
    chk("t1_no_early_valid", 32'(out_valid_a), 32'd0);
    send(16'h0004, 1'b0);
    chk("t1_latency_valid", 32'(out_valid_a), 32'd1);
    out_ready = 1'b0;

    // 2: back-pressure freezes outputs and blocks input
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_in_ready_low",  32'(in_ready_a),  32'd0);
      chk("t2_valid_held",    32'(out_valid_a), 32'd1);
      chk("t2_total_frozen",  32'(out_total_a), 32'h00000A);
      chk("t2_count_frozen",  32'(out_count_a), 32'd4);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push_exp(32'h0000A0, 1'b0, 32'h0000A0, 1'b0, 8'd4);
    send(16'h0010, 1'b0);
    send(16'h0020, 1'b0);
    send(16'h0030, 1'b0);
    send(16'h0040, 1'b0);

    // 3: wrap behaviour, first beat overlaps the previous handoff
    push_exp(32'h03FFFC, 1'b0, 32'h1FFFC, 1'b1, 8'd4);
    for (int i = 0; i < 4; i++) send(16'hFFFF, 1'b0);

    // 4: flush alone, then flush coincident with a beat
    push_exp(32'h000300, 1'b0, 32'h000300, 1'b0, 8'd2);
    send(16'h0100, 1'b0);
    send(16'h0200, 1'b0);
    do_flush();
    push_exp(32'h000700, 1'b0, 32'h000700, 1'b0, 8'd3);
    send(16'h0100, 1'b0);
    send(16'h0200, 1'b0);
    send(16'h0400, 1'b1);

    // flush while idle produces nothing
    idle_cycles(3);
    do_flush();
    idle_cycles(3);
    chk("idle_flush_no_valid", 32'(out_valid_a), 32'd0);

    // 5: asynchronous reset mid-block discards the partial sum
    send(16'h0011, 1'b0);
    send(16'h0022, 1'b0);
    send(16'h0033, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("t5_rst_total",    32'(out_total_a), 32'd0);
    chk("t5_rst_count",    32'(out_count_a), 32'd0);
    chk("t5_rst_ovf",      32'(out_ovf_a),   32'd0);
    chk("t5_rst_valid",    32'(out_valid_a), 32'd0);
    chk("t5_rst_in_ready", 32'(in_ready_a),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(1);
    push_exp(32'h00001A, 1'b0, 32'h00001A, 1'b0, 8'd4);
    send(16'h0005, 1'b0);
    send(16'h0006, 1'b0);
    send(16'h0007, 1'b0);
    send(16'h0008, 1'b0);

    // 6: gaps with garbage on in_sum while in_valid is low
    push_exp(32'h00000A, 1'b0, 32'h00000A, 1'b0, 8'd4);
    for (int i = 1; i <= 4; i++) begin
      in_sum = 16'hBEEF;
      idle_cycles(int'($urandom_range(0, 3)));
      send(16'(i), 1'b0);
    end

    // drain and confirm every expected block appeared
    for (int i = 0; i < 50; i++) begin
      if (q_a.size() == 0 && q_b.size() == 0) break;
      @(posedge clk);
      #1;
    end
    idle_cycles(2);
    chk("a_queue_drained", 32'(q_a.size()), 32'd0);
    chk("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
